instr_decode_pipe: RTL and testbench

INSTR_DECODE_PIPE -- requirements
Module: instr_decode_pipe

---
 rtl/instr_decode_pipe.sv | 171 +++++++++++++++++
 tb/tb_instr_decode_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_pipe.sv
// RV32 instruction field/immediate decoder feeding a DEPTH-entry output FIFO.
// Latency: one cycle from accept into an empty FIFO to out_valid.
// Backpressure: in_ready from registered occupancy only; DECODE_ILLEGAL_EN adds illegal-encoding flag.
module instr_decode_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opc,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_type,
  output logic            out_illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] T_R  = 3'd0;
  localparam logic [2:0] T_I  = 3'd1;
  localparam logic [2:0] T_SH = 3'd2;
  localparam logic [2:0] T_S  = 3'd3;
  localparam logic [2:0] T_B  = 3'd4;
  localparam logic [2:0] T_U  = 3'd5;
  localparam logic [2:0] T_J  = 3'd6;

  typedef struct packed {
    logic [6:0]      opc;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_type;
`ifdef DECODE_ILLEGAL_EN
    logic            illegal;
`endif
  } rec_t;

  logic [2:0]      raw_type;
  logic [2:0]      dec_type;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  rec_t            dec;

  always_comb begin
    raw_type = T_R;
    case (in_instr[6:0])
      7'b0110011:                         raw_type = T_R;
      7'b0000011, 7'b1100111, 7'b1110011: raw_type = T_I;
      7'b0010011: raw_type = (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101) ? T_SH : T_I;
      7'b0100011:                         raw_type = T_S;
      7'b1100011:                         raw_type = T_B;
      7'b0110111, 7'b0010111:             raw_type = T_U;
      7'b1101111:                         raw_type = T_J;
      default:                            raw_type = T_R;
    endcase
  end

`ifdef DECODE_ILLEGAL_EN
  // Unlisted opcodes are exactly those that fall to R without being the R opcode.
  assign dec_illegal = (in_instr[1:0] != 2'b11) ||
                       (raw_type == T_R && in_instr[6:0] != 7'b0110011) ||
                       (in_instr == 32'h0);
`else
  assign dec_illegal = 1'b0;
`endif

  assign dec_type = dec_illegal ? T_R : raw_type;

  always_comb begin
    dec_imm = '0;
    case (dec_type)
      T_I:  dec_imm = XLEN'($signed(in_instr[31:20]));
      T_SH: dec_imm = (XLEN == 32) ? XLEN'(in_instr[24:20]) : XLEN'(in_instr[25:20]);
      T_S:  dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      T_B:  dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                     in_instr[11:8], 1'b0}));
      T_U:  dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      T_J:  dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                     in_instr[30:21], 1'b0}));
      default: dec_imm = '0;
    endcase
  end

  always_comb begin
    dec          = '0;
    dec.opc      = in_instr[6:0];
    dec.func3    = in_instr[14:12];
    dec.func7    = in_instr[31:25];
    dec.rs1      = in_instr[19:15];
    dec.rs2      = in_instr[24:20];
    dec.rd       = in_instr[11:7];
    dec.imm      = dec_imm;
    dec.imm_type = dec_type;
`ifdef DECODE_ILLEGAL_EN
    dec.illegal  = dec_illegal;
`endif
  end

  rec_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          rdy_en;
  logic          push;
  logic          pop;

  // rdy_en keeps in_ready low while in reset even though count is already 0.
  assign in_ready  = rdy_en && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= dec;
  end

  rec_t head;
  assign head         = mem[rd_ptr];
  assign out_opc      = head.opc;
  assign out_func3    = head.func3;
  assign out_func7    = head.func7;
  assign out_rs1      = head.rs1;
  assign out_rs2      = head.rs2;
  assign out_rd       = head.rd;
  assign out_imm      = head.imm;
  assign out_imm_type = head.imm_type;
`ifdef DECODE_ILLEGAL_EN
  assign out_illegal  = head.illegal;
`else
  assign out_illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Randomized bench for instr_decode_pipe against a queue-based decode model.
module tb_instr_decode_pipe;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_opc;
  logic [2:0]      out_func3;
  logic [6:0]      out_func7;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_imm_type;
  logic            out_illegal;

  int errs   = 0;
  int checks = 0;

  instr_decode_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opc(out_opc), .out_func3(out_func3), .out_func7(out_func7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_imm_type(out_imm_type), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit m_listed(input logic [31:0] i);
    case (i[6:0])
      7'h33, 7'h03, 7'h67, 7'h73, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_illegal(input logic [31:0] i);
`ifdef DECODE_ILLEGAL_EN
    return (i[1:0] != 2'b11) || !m_listed(i) || (i == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_type(input logic [31:0] i);
    if (m_illegal(i)) return 0;
    case (i[6:0])
      7'h03, 7'h67, 7'h73: return 1;
      7'h13:               return (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? 2 : 1;
      7'h23:               return 3;
      7'h63:               return 4;
      7'h37, 7'h17:        return 5;
      7'h6F:               return 6;
      default:             return 0;
    endcase
  endfunction

  // Immediate values built arithmetically, then wrapped to XLEN bits.
  function automatic logic [XLEN-1:0] m_imm(input logic [31:0] i);
    longint v;
    v = 0;
    case (m_type(i))
      1: begin v = longint'(i[31:20]); if (v >= 2048) v -= 4096; end
      2: v = (XLEN == 32) ? longint'(i[24:20]) : longint'(i[25:20]);
      3: begin v = longint'(i[31:25]) * 32 + longint'(i[11:7]); if (v >= 2048) v -= 4096; end
      4: begin
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
            + longint'(i[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      5: begin v = longint'(i[31:12]) * 4096; if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000; end
      6: begin
        v = longint'(i[31]) * (1 << 20) + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
            + longint'(i[30:21]) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
      end
      default: v = 0;
    endcase
    return v[XLEN-1:0];
  endfunction

  logic [31:0] q[$];
  logic        m_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_rdy <= 1'b0;
    end else begin
      m_rdy <= 1'b1;
      if (flush) q.delete();
      else if (q.size() != 0 && out_ready) begin
        if (in_valid && m_rdy && q.size() < DEPTH) q.push_back(in_instr);
        void'(q.pop_front());
      end else if (in_valid && m_rdy && q.size() < DEPTH) q.push_back(in_instr);
    end
  end

  always @(negedge clk) begin
    logic [31:0] h;
    chk("in_ready", in_ready, m_rdy && (q.size() < DEPTH));
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      h = q[0];
      chk("opc", out_opc, h[6:0]);
      chk("func3", out_func3, h[14:12]);
      chk("func7", out_func7, h[31:25]);
      chk("rs1", out_rs1, h[19:15]);
      chk("rs2", out_rs2, h[24:20]);
      chk("rd", out_rd, h[11:7]);
      chk("imm", out_imm, m_imm(h));
      chk("imm_type", out_imm_type, m_type(h));
      chk("illegal", out_illegal, m_illegal(h));
    end
  end

  logic [6:0] ops [10];

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 9)]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push1(input logic [31:0] instr);
    in_instr = instr;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  logic ill_exp;

  initial begin
    ops = '{7'h33, 7'h03, 7'h67, 7'h73, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    flush = 0; in_valid = 0; out_ready = 0; in_instr = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    chk("model_addi_imm", m_imm(32'hFFF00093), 64'hFFFF_FFFF);
    chk("model_srli_type", m_type(32'h0050D093), 2);
    chk("model_srli_imm", m_imm(32'h0050D093), 5);
    chk("model_beq_imm", m_imm(32'hFE000EE3), 64'hFFFF_FFFC);
    chk("model_lui_imm", m_imm(32'h123450B7), 64'h1234_5000);
    chk("model_jal_imm", m_imm(32'h0080006F), 8);

    cyc();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("ready_after_reset", in_ready, 1);

    out_ready = 1'b1;
    push1(32'hFFF00093);
    chk("addi_valid", out_valid, 1);
    chk("addi_imm", out_imm, 64'hFFFF_FFFF);
    chk("addi_type", out_imm_type, 1);
    chk("addi_rd", out_rd, 1);
    chk("addi_rs1", out_rs1, 0);
    cyc();
    push1(32'h0050D093);
    chk("srli_type", out_imm_type, 2);
    chk("srli_imm", out_imm, 5);
    cyc();
    push1(32'hFE000EE3);
    chk("beq_type", out_imm_type, 4);
    chk("beq_imm", out_imm, 64'hFFFF_FFFC);
    cyc();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      in_instr = rnd_instr();
      cyc();
    end
    chk("full_in_ready", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      in_instr = rnd_instr();
      cyc();
    end
    chk("full_still_blocked", in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH) cyc();
    chk("drained", out_valid, 0);

    out_ready = 1'b0;
    push1(rnd_instr());
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_instr = rnd_instr();
      cyc();
      chk("one_entry_valid", out_valid, 1);
      chk("one_entry_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    cyc();
    chk("one_entry_drained", out_valid, 0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      in_instr = rnd_instr();
      cyc();
    end
    chk("flush_full", in_ready, 0);
    flush    = 1'b1;
    in_instr = rnd_instr();
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);

`ifdef DECODE_ILLEGAL_EN
    ill_exp = 1'b1;
`else
    ill_exp = 1'b0;
`endif
    out_ready = 1'b1;
    push1(32'h0000_0000);
    chk("ill_zero", out_illegal, ill_exp);
    chk("ill_zero_imm", out_imm, 0);
    cyc();
    push1(32'h0000_007F);
    chk("ill_7f", out_illegal, ill_exp);
    chk("ill_7f_type", out_imm_type, 0);
    cyc();
    push1(32'h0000_0013);
    chk("legal_nop", out_illegal, 0);
    cyc();

    for (int k = 0; k < 1500; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_instr  = rnd_instr();
      cyc();
    end
    flush = 1'b0;

    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (3) begin
      in_instr = rnd_instr();
      cyc();
    end
    in_valid = 1'b0;
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
